fifo_rd_packer: RTL

Read-side consumer for the nibble FIFO, clocked in the read domain. Pops 4-bit entries from the FIFO whenever it is non-empty, assembles NIBBLES consecutive entries into one wide word (first entry in LSBs), and presents the word on a valid/ready output port. Sits directly between the FIFO read port (pop/Data_Out/Empty/Data_Valid) and downstream read-domain logic.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/packer_idle_timer.sv | 28 ++
 rtl/fifo_rd_packer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and state encoding for the nibble FIFO read side.
// Holds entry width, packer defaults and the packer FSM state enum.
package fifo_pkg;

   localparam int DATA_W         = 4;
   localparam int NIBBLES_DEF    = 2;
   localparam int DV_TIMEOUT_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      POP,
      WAIT,
      OUT
   } pk_state_e;

endpackage

// File: rtl/packer_idle_timer.sv
// packer_idle_timer: loadable down-counter, expired on its final counted cycle.
// Used for the data-valid timeout and the optional partial-word flush timer.
module packer_idle_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign expired = (cnt == W'(1));

endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops FIFO nibbles and packs NIBBLES of them into one word.
// Define PACKER_FLUSH_EN to flush a partial word after FLUSH_CYCLES idle cycles.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int DATA_W     = fifo_pkg::DATA_W,
   parameter int NIBBLES    = NIBBLES_DEF,
   parameter int DV_TIMEOUT = DV_TIMEOUT_DEF
`ifdef PACKER_FLUSH_EN
   ,
   parameter int FLUSH_CYCLES = 16
`endif
) (
   input  logic                        RD_CLK,
   input  logic                        rst_n,
   input  logic                        fifo_empty,
   input  logic [DATA_W-1:0]           fifo_data,
   input  logic                        fifo_data_valid,
   output logic                        fifo_pop,
   output logic [DATA_W*NIBBLES-1:0]   out_data,
   output logic [$clog2(NIBBLES+1)-1:0] out_len,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        err_timeout
);

   localparam int CW  = $clog2(NIBBLES+1);
   localparam int DVW = $clog2(DV_TIMEOUT+1);

   pk_state_e state, state_nxt;

   logic [DATA_W*NIBBLES-1:0] acc;
   logic [CW-1:0]             cnt;
   logic                      store, clr, set_err;
   logic                      dv_load, dv_en, dv_exp;
   logic                      flush_go;

   assign dv_load = (state == POP);
   assign dv_en   = (state == WAIT);

   packer_idle_timer #(.W(DVW)) u_dv_tmr (
      .clk      (RD_CLK),
      .rst_n    (rst_n),
      .load     (dv_load),
      .en       (dv_en),
      .load_val (DVW'(DV_TIMEOUT)),
      .expired  (dv_exp)
   );

`ifdef PACKER_FLUSH_EN
   localparam int FW = $clog2(FLUSH_CYCLES+1);

   logic fl_cond, fl_exp;

   // Any non-idle cycle, pop or fresh entry restarts the idle window.
   assign fl_cond = (state == IDLE) && (cnt != '0) && fifo_empty;

   packer_idle_timer #(.W(FW)) u_fl_tmr (
      .clk      (RD_CLK),
      .rst_n    (rst_n),
      .load     (!fl_cond),
      .en       (fl_cond),
      .load_val (FW'(FLUSH_CYCLES)),
      .expired  (fl_exp)
   );

   assign flush_go = fl_cond && fl_exp;
`else
   assign flush_go = 1'b0;
`endif

   always_ff @(posedge RD_CLK) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      fifo_pop  = 1'b0;
      out_valid = 1'b0;
      store     = 1'b0;
      clr       = 1'b0;
      set_err   = 1'b0;
      unique case (state)
         IDLE: begin
            if (flush_go) begin
               state_nxt = OUT;
            end else if (!fifo_empty) begin
               state_nxt = POP;
            end
         end
         POP: begin
            fifo_pop  = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (fifo_data_valid) begin
               store     = 1'b1;
               state_nxt = (cnt == CW'(NIBBLES-1)) ? OUT : IDLE;
            end else if (dv_exp) begin
               set_err   = 1'b1;
               state_nxt = IDLE;
            end
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               clr       = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge RD_CLK) begin
      if (!rst_n) begin
         acc         <= '0;
         cnt         <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (set_err) begin
            err_timeout <= 1'b1;
         end
         if (clr) begin
            acc <= '0;
            cnt <= '0;
         end else if (store) begin
            for (int k = 0; k < NIBBLES; k++) begin
               if (cnt == CW'(k)) begin
                  acc[k*DATA_W +: DATA_W] <= fifo_data;
               end
            end
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign out_data = acc;
   assign out_len  = (state == OUT) ? cnt : '0;

endmodule
